// File: rtl/dcache_pkg.sv
// Shared types and tag-field constants for the data-cache port arbiter and the cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_LD = 2'd1,
    GRANT_ST = 2'd2
  } arb_state_t;

  // Tag layout {rw, memory/mmio, data/insn, id}: offsets are counted down from the MSB.
  localparam int TAG_RW_OFS   = 1;
  localparam int TAG_MEM_OFS  = 2;
  localparam int TAG_DATA_OFS = 3;
  localparam int TAG_HDR_W    = 3;

  localparam int ID_LD = 0;
  localparam int ID_ST = 1;

  localparam logic RW_READ    = 1'b0;
  localparam logic RW_WRITE   = 1'b1;
  localparam logic SPACE_MEM  = 1'b0;
  localparam logic SPACE_MMIO = 1'b1;
  localparam logic KIND_DATA  = 1'b0;
  localparam logic KIND_INSN  = 1'b1;

  localparam int STARVE_W = 3;

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// One cache request/response handshake; master issues requests, slave answers them.
interface dcache_port_if #(parameter int TAG_W = 13);
  logic             reqcyc;
  logic [63:0]      req;
  logic [63:0]      reqdata;
  logic [TAG_W-1:0] reqtag;
  logic             reqack;
  logic             respcyc;
  logic [63:0]      resp;
  logic [TAG_W-1:0] resptag;
  logic             respack;

  modport master (
    output reqcyc, req, reqdata, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqdata, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/dcache_req_latch.sv
// Holding register for the granted request; it drives the cache port fields directly.
module dcache_req_latch #(
  parameter int TAG_W = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [63:0]      reqIn,
  input  logic [63:0]      dataIn,
  input  logic [TAG_W-1:0] tagIn,
  output logic [63:0]      reqOut,
  output logic [63:0]      dataOut,
  output logic [TAG_W-1:0] tagOut
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reqOut  <= '0;
      dataOut <= '0;
      tagOut  <= '0;
    end else if (en) begin
      reqOut  <= reqIn;
      dataOut <= dataIn;
      tagOut  <= tagIn;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single data-cache port between the load and store paths; one request in
// flight, store preferred, with a saturating counter that bounds load starvation.
module dcache_port_arbiter
  import dcache_pkg::*;
#(
  parameter int TAG_W      = 13,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  dcache_port_if.slave  ld,
  dcache_port_if.slave  st,
  dcache_port_if.master c
);

  localparam int ID_W = TAG_W - TAG_HDR_W;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t          state, nextState;
  logic [STARVE_W-1:0] starveCnt, nextCnt;
  logic                latchEn, latchSt;
  logic [63:0]         selReq, selData;
  logic [TAG_W-1:0]    selTag, srcTag;
  logic                respIsLd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      starveCnt <= '0;
    end else begin
      state     <= nextState;
      starveCnt <= nextCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = starveCnt;
    latchEn   = 1'b0;
    latchSt   = 1'b0;
    ld.reqack = 1'b0;
    st.reqack = 1'b0;
    case (state)
      IDLE: begin
        if (st.reqcyc && starveCnt < STARVE_LIM) begin
          nextState = GRANT_ST;
          latchEn   = 1'b1;
          latchSt   = 1'b1;
          nextCnt   = ld.reqcyc ? starveCnt + 1'b1 : '0;
        end else if (ld.reqcyc) begin
          nextState = GRANT_LD;
          latchEn   = 1'b1;
          nextCnt   = '0;
        end else if (st.reqcyc) begin
          nextCnt = '0;
        end
      end
      GRANT_LD: if (c.reqack) begin
        ld.reqack = 1'b1;
        nextState = IDLE;
      end
      GRANT_ST: if (c.reqack) begin
        st.reqack = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // The id field tells the response path which requester owns the reply.
  always_comb begin
    selReq  = latchSt ? st.req     : ld.req;
    selData = latchSt ? st.reqdata : ld.reqdata;
    srcTag  = latchSt ? st.reqtag  : ld.reqtag;
    selTag  = {srcTag[TAG_W-1 -: TAG_HDR_W], ID_W'(latchSt ? ID_ST : ID_LD)};
  end

  dcache_req_latch #(.TAG_W(TAG_W)) uLatch (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (latchEn),
    .reqIn   (selReq),
    .dataIn  (selData),
    .tagIn   (selTag),
    .reqOut  (c.req),
    .dataOut (c.reqdata),
    .tagOut  (c.reqtag)
  );

  assign c.reqcyc = (state != IDLE);

  // Responses bypass the request FSM so they can overlap a new grant.
  assign respIsLd   = (c.resptag[ID_W-1:0] == ID_W'(ID_LD));
  assign ld.respcyc = c.respcyc & respIsLd;
  assign st.respcyc = c.respcyc & ~respIsLd;
  assign c.respack  = respIsLd ? ld.respack : st.respack;
  assign ld.resp    = c.resp;
  assign st.resp    = c.resp;
  assign ld.resptag = c.resptag;
  assign st.resptag = c.resptag;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench: expected cache requests queue per requester, popped as the cache accepts.
module tb_dcache_port_arbiter;
  import dcache_pkg::*;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [12:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  exp_t ldQ[$];
  exp_t stQ[$];

  dcache_port_if #(.TAG_W(13)) ldIf ();
  dcache_port_if #(.TAG_W(13)) stIf ();
  dcache_port_if #(.TAG_W(13)) cIf ();

  dcache_port_arbiter #(.TAG_W(13), .STARVE_MAX(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (ldIf),
    .st      (stIf),
    .c       (cIf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] mkTag(input logic rw, input logic mem, input logic kind,
                                        input logic [9:0] id);
    return {rw, mem, kind, id};
  endfunction

  task automatic drvLd(input logic [63:0] a, input logic [12:0] t);
    exp_t e;
    ldIf.reqcyc = 1'b1; ldIf.req = a; ldIf.reqdata = '0; ldIf.reqtag = t;
    e.addr = a; e.data = '0; e.tag = {t[12:10], 10'd0};
    ldQ.push_back(e);
  endtask

  task automatic drvSt(input logic [63:0] a, input logic [12:0] t, input logic [63:0] d);
    exp_t e;
    stIf.reqcyc = 1'b1; stIf.req = a; stIf.reqdata = d; stIf.reqtag = t;
    e.addr = a; e.data = d; e.tag = {t[12:10], 10'd1};
    stQ.push_back(e);
  endtask

  // Called at a negedge where a grant is expected; accepts it after waitN cycles.
  task automatic serve(input int waitN, input int who);
    exp_t e;
    int   qsz;
    qsz = (who == 0) ? ldQ.size() : stQ.size();
    chk("queue_nonempty", 64'(qsz > 0), 64'd1);
    if (qsz == 0) return;
    e = (who == 0) ? ldQ.pop_front() : stQ.pop_front();
    chk("c_reqcyc_grant", cIf.reqcyc, 1'b1);
    chk("c_req", cIf.req, e.addr);
    chk("c_reqdata", cIf.reqdata, e.data);
    chk("c_reqtag", cIf.reqtag, 64'(e.tag));
    repeat (waitN) begin
      chk("ld_reqack_wait", ldIf.reqack, 1'b0);
      chk("st_reqack_wait", stIf.reqack, 1'b0);
      tick();
      chk("c_reqcyc_hold", cIf.reqcyc, 1'b1);
    end
    cIf.reqack = 1'b1;
    #1;
    chk("ld_reqack_pulse", ldIf.reqack, 64'(who == 0));
    chk("st_reqack_pulse", stIf.reqack, 64'(who == 1));
    tick();
    cIf.reqack = 1'b0;
    if (who == 0) ldIf.reqcyc = 1'b0; else stIf.reqcyc = 1'b0;
    #1;
    chk("c_reqcyc_bubble", cIf.reqcyc, 1'b0);
    chk("ld_reqack_after", ldIf.reqack, 1'b0);
    chk("st_reqack_after", stIf.reqack, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    ldIf.reqcyc = 0; ldIf.req = '0; ldIf.reqdata = '0; ldIf.reqtag = '0; ldIf.respack = 0;
    stIf.reqcyc = 0; stIf.req = '0; stIf.reqdata = '0; stIf.reqtag = '0; stIf.respack = 0;
    cIf.reqack = 0; cIf.respcyc = 0; cIf.resp = '0; cIf.resptag = '0;
    repeat (2) tick();
    chk("rst_c_reqcyc", cIf.reqcyc, 1'b0);
    chk("rst_c_req", cIf.req, 64'd0);
    chk("rst_c_reqdata", cIf.reqdata, 64'd0);
    chk("rst_c_reqtag", cIf.reqtag, 64'd0);
    chk("rst_ld_reqack", ldIf.reqack, 1'b0);
    chk("rst_st_reqack", stIf.reqack, 1'b0);
    chk("rst_ld_respcyc", ldIf.respcyc, 1'b0);
    chk("rst_st_respcyc", stIf.respcyc, 1'b0);
    reset_n = 1'b1;
    tick();

    // load only, accepted two cycles after c_reqcyc rises
    drvLd(64'h1000, mkTag(RW_READ, SPACE_MEM, KIND_DATA, 10'h3FF));
    tick();
    serve(2, 0);
    cIf.respcyc = 1'b1; cIf.resptag = mkTag(RW_READ, SPACE_MEM, KIND_DATA, 10'd0);
    cIf.resp = 64'hCAFE_F00D; ldIf.respack = 1'b1;
    #1;
    chk("t1_ld_respcyc", ldIf.respcyc, 1'b1);
    chk("t1_st_respcyc", stIf.respcyc, 1'b0);
    chk("t1_ld_resp", ldIf.resp, 64'hCAFE_F00D);
    chk("t1_c_respack", cIf.respack, 1'b1);
    tick();
    cIf.respcyc = 1'b0; ldIf.respack = 1'b0;
    #1;
    chk("t1_ld_respcyc_off", ldIf.respcyc, 1'b0);

    // store only
    drvSt(64'h2008, mkTag(RW_WRITE, SPACE_MEM, KIND_DATA, 10'h0AB), 64'hDEAD);
    tick();
    chk("t2_rw_bit", 64'(cIf.reqtag[12]), 64'(RW_WRITE));
    serve(1, 1);

    // simultaneous: store first, load two cycles after the store's acceptance
    drvLd(64'h3000, mkTag(RW_READ, SPACE_MEM, KIND_DATA, 10'h011));
    drvSt(64'h3008, mkTag(RW_WRITE, SPACE_MEM, KIND_DATA, 10'h022), 64'h1234);
    tick();
    serve(0, 1);
    tick();
    serve(0, 0);

    // starvation bound: four stores, then the waiting load, then stores resume
    drvLd(64'h4000, mkTag(RW_READ, SPACE_MMIO, KIND_DATA, 10'h000));
    drvSt(64'h5000, mkTag(RW_WRITE, SPACE_MEM, KIND_DATA, 10'h000), 64'h50);
    for (int i = 0; i < 4; i++) begin
      tick();
      serve(0, 1);
      drvSt(64'h5000 + 64'(8 * (i + 1)), mkTag(RW_WRITE, SPACE_MEM, KIND_DATA, 10'h000),
            64'h51 + 64'(i));
    end
    tick();
    serve(0, 0);
    tick();
    serve(0, 1);

    // reset during a store grant with the counter saturated
    drvLd(64'h6000, mkTag(RW_READ, SPACE_MEM, KIND_DATA, 10'h000));
    drvSt(64'h6100, mkTag(RW_WRITE, SPACE_MEM, KIND_DATA, 10'h000), 64'h61);
    for (int i = 0; i < 3; i++) begin
      tick();
      serve(0, 1);
      drvSt(64'h6108 + 64'(8 * i), mkTag(RW_WRITE, SPACE_MEM, KIND_DATA, 10'h000), 64'h62);
    end
    tick();
    chk("t5_grant_before_rst", cIf.reqcyc, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_c_reqcyc", cIf.reqcyc, 1'b0);
    chk("t5_async_c_req", cIf.req, 64'd0);
    chk("t5_async_c_reqtag", cIf.reqtag, 64'd0);
    ldQ.delete(); stQ.delete();
    ldIf.reqcyc = 1'b0; stIf.reqcyc = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    drvLd(64'h6200, mkTag(RW_READ, SPACE_MEM, KIND_INSN, 10'h000));
    drvSt(64'h6300, mkTag(RW_WRITE, SPACE_MEM, KIND_DATA, 10'h000), 64'h63);
    tick();
    serve(0, 1);
    tick();
    serve(0, 0);

    // responses during an active store grant
    drvSt(64'h7000, mkTag(RW_WRITE, SPACE_MEM, KIND_DATA, 10'h155), 64'h7777);
    tick();
    cIf.respcyc = 1'b1; cIf.resptag = mkTag(RW_READ, SPACE_MEM, KIND_DATA, 10'd0);
    cIf.resp = 64'hBEEF; ldIf.respack = 1'b1; stIf.respack = 1'b0;
    #1;
    chk("t6_ld_respcyc", ldIf.respcyc, 1'b1);
    chk("t6_st_respcyc", stIf.respcyc, 1'b0);
    chk("t6_ld_resp", ldIf.resp, 64'hBEEF);
    chk("t6_c_respack_hi", cIf.respack, 1'b1);
    ldIf.respack = 1'b0; stIf.respack = 1'b1;
    #1;
    chk("t6_c_respack_lo", cIf.respack, 1'b0);
    cIf.resptag = mkTag(RW_WRITE, SPACE_MEM, KIND_DATA, 10'd1);
    #1;
    chk("t6_st_respcyc", stIf.respcyc, 1'b1);
    chk("t6_ld_respcyc_off", ldIf.respcyc, 1'b0);
    chk("t6_c_respack_st", cIf.respack, 1'b1);
    chk("t6_grant_held", cIf.reqcyc, 1'b1);
    cIf.respcyc = 1'b0; stIf.respack = 1'b0;
    serve(1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
